// File: rtl/wb_trace_fifo.sv
// Writeback-stage trace capture: first-word-fall-through FIFO of retiring register writes with drop accounting.
// Optional build macro WB_TRACE_TIMESTAMP_EN adds a cycle-counter stamp to each entry and an out_stamp port.
module wb_trace_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              trace_en,
  input  logic              clr_ovf,
  input  logic [31:0]       PCW,
  input  logic              RegWriteW,
  input  logic [4:0]        WriteRegW,
  input  logic [31:0]       ResultW,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_pc,
  output logic [4:0]        out_reg,
  output logic [31:0]       out_data,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic [15:0]       drop_count
`ifdef WB_TRACE_TIMESTAMP_EN
  ,
  output logic [31:0]       out_stamp
`endif
);

`ifdef WB_TRACE_TIMESTAMP_EN
  localparam int ENTRY_W = 101;
`else
  localparam int ENTRY_W = 69;
`endif
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [ENTRY_W-1:0] entryIn;
  logic [ENTRY_W-1:0] head;
  logic [ADDR_W-1:0]  wrPtr;
  logic [ADDR_W-1:0]  rdPtr;
  logic               capture;
  logic               full;
  logic               pop;
  logic               push;
  logic               drop;

  assign capture   = trace_en & RegWriteW & (WriteRegW != 5'd0);
  assign full      = (count == FULL_CNT);
  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready;
  // A full FIFO still accepts a capture when the head leaves in the same cycle.
  assign push      = capture & (~full | pop);
  assign drop      = capture & full & ~pop;

`ifdef WB_TRACE_TIMESTAMP_EN
  logic [31:0] cycleCnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cycleCnt <= '0;
    else        cycleCnt <= cycleCnt + 32'd1;
  end

  assign entryIn = {cycleCnt, PCW, WriteRegW, ResultW};
`else
  assign entryIn = {PCW, WriteRegW, ResultW};
`endif

  // NOTE: storage has no reset; stale words are never visible because outputs are gated by out_valid.
  always_ff @(posedge clk) begin
    if (push) mem[wrPtr] <= entryIn;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // A drop coinciding with a clear leaves a count of exactly that one drop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (clr_ovf) begin
      overflow   <= 1'b0;
      drop_count <= drop ? 16'd1 : 16'd0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
    end
  end

  assign head = mem[rdPtr];

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    out_pc   = '0;
    out_reg  = '0;
    out_data = '0;
`ifdef WB_TRACE_TIMESTAMP_EN
    out_stamp = '0;
`endif
    if (out_valid) begin
      out_data = head[31:0];
      out_reg  = head[36:32];
      out_pc   = head[68:37];
`ifdef WB_TRACE_TIMESTAMP_EN
      out_stamp = head[100:69];
`endif
    end
  end

endmodule
